// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: transmit FSM encoding and framing constants.
package uart_defs;

   typedef enum logic [1:0] {
      TXQ_IDLE  = 2'b00,
      TXQ_START = 2'b01,
      TXQ_DATA  = 2'b10,
      TXQ_STOP  = 2'b11
   } txq_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_CPB_MIN   = 2;

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serializer: pulls one byte from the queue head when idle and shifts it
// out LSB first with a start and a stop bit. All outputs except pop are registered.
module uart_tx_shifter
   import uart_defs::*;
#(
   parameter int CPB_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 tx_en,
   input  logic                 empty,
   input  logic [7:0]           head_data,
   input  logic [CPB_WIDTH-1:0] cycles_per_bit,
   output logic                 pop,
   output logic                 txd,
   output logic                 busy
);

   localparam logic [CPB_WIDTH-1:0] CPB_MIN  = CPB_WIDTH'(UART_CPB_MIN);
   localparam logic [CPB_WIDTH-1:0] CPB_ONE  = CPB_WIDTH'(1);
   localparam logic [2:0]           LAST_BIT = 3'(UART_DATA_BITS - 1);

   txq_state_t           state;
   logic [CPB_WIDTH-1:0] cpb_q;
   logic [CPB_WIDTH-1:0] per_cnt;
   logic [2:0]           bit_cnt;
   logic [7:0]           shift;
   logic [CPB_WIDTH-1:0] eff_new;
   logic [CPB_WIDTH-1:0] eff_q;

   // Bit period is clamped to at least two clocks; the live input is only
   // used at load time, the latched copy for the rest of the frame.
   assign eff_new = (cycles_per_bit < CPB_MIN) ? CPB_MIN : cycles_per_bit;
   assign eff_q   = (cpb_q < CPB_MIN) ? CPB_MIN : cpb_q;

   // Head byte is consumed in the same cycle the frame is launched.
   assign pop = (state == TXQ_IDLE) && tx_en && !empty;

   // Frame sequencer: period counter counts down to 0, bit counter walks the data bits.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= TXQ_IDLE;
         txd     <= 1'b1;
         busy    <= 1'b0;
         cpb_q   <= '0;
         per_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         case (state)
            TXQ_IDLE: begin
               if (pop) begin
                  shift   <= head_data;
                  cpb_q   <= cycles_per_bit;
                  per_cnt <= eff_new - CPB_ONE;
                  txd     <= 1'b0;
                  busy    <= 1'b1;
                  state   <= TXQ_START;
               end
            end
            TXQ_START: begin
               if (per_cnt == '0) begin
                  per_cnt <= eff_q - CPB_ONE;
                  bit_cnt <= '0;
                  txd     <= shift[0];
                  shift   <= {1'b0, shift[7:1]};
                  state   <= TXQ_DATA;
               end else begin
                  per_cnt <= per_cnt - CPB_ONE;
               end
            end
            TXQ_DATA: begin
               if (per_cnt == '0) begin
                  per_cnt <= eff_q - CPB_ONE;
                  if (bit_cnt == LAST_BIT) begin
                     txd   <= 1'b1;
                     state <= TXQ_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     txd     <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end else begin
                  per_cnt <= per_cnt - CPB_ONE;
               end
            end
            TXQ_STOP: begin
               if (per_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= TXQ_IDLE;
               end else begin
                  per_cnt <= per_cnt - CPB_ONE;
               end
            end
            default: begin
               txd   <= 1'b1;
               busy  <= 1'b0;
               state <= TXQ_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered 8N1 transmitter: byte FIFO in front of uart_tx_shifter. Overflowing
// writes are discarded and counted so software can detect lost bytes.
module uart_tx_queue
   import uart_defs::*;
#(
   parameter int AWIDTH    = 4,
   parameter int CPB_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 tx_en,
   input  logic                 wr_en,
   input  logic [7:0]           wr_data,
   input  logic [CPB_WIDTH-1:0] cycles_per_bit,
   output logic                 txd,
   output logic                 busy,
   output logic                 tc,
   output logic                 full,
   output logic                 empty,
   output logic [AWIDTH:0]      level,
   output logic [7:0]           drop_count
);

   localparam int              DEPTH    = 1 << AWIDTH;
   localparam logic [AWIDTH:0] FULL_LVL = DEPTH[AWIDTH:0];
   localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

   logic [7:0]        mem [DEPTH];
   logic [AWIDTH-1:0] wptr;
   logic [AWIDTH-1:0] rptr;
   logic              pop;
   logic              push;

   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);
   assign tc    = empty && !busy;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push  = wr_en && (!full || pop);

   // Storage needs no reset: level gates every read of it.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

   // Pointers, occupancy and overflow counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr       <= '0;
         rptr       <= '0;
         level      <= '0;
         drop_count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (wr_en && !push) drop_count <= drop_count + 8'd1;
      end
   end

   uart_tx_shifter #(
      .CPB_WIDTH(CPB_WIDTH)
   ) u_shifter (
      .clk            (clk),
      .resetn         (resetn),
      .tx_en          (tx_en),
      .empty          (empty),
      .head_data      (mem[rptr]),
      .cycles_per_bit (cycles_per_bit),
      .pop            (pop),
      .txd            (txd),
      .busy           (busy)
   );

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected frames, a
// monitor decodes txd cycle by cycle and checks byte value and bit timing.
module tb_uart_tx_queue;

   logic        clk;
   logic        resetn;
   logic        tx_en;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic [31:0] cycles_per_bit;
   logic        txd, busy, tc, full, empty;
   logic [4:0]  level;
   logic [7:0]  drop_count;

   typedef struct {
      logic [7:0] data;
      int         eff;
      bit         gap;
      bit         abort;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   bit   mon_act = 0;

   uart_tx_queue #(.AWIDTH(4), .CPB_WIDTH(32)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .tx_en          (tx_en),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .cycles_per_bit (cycles_per_bit),
      .txd            (txd),
      .busy           (busy),
      .tc             (tc),
      .full           (full),
      .empty          (empty),
      .level          (level),
      .drop_count     (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] b, input int eff, input bit gap,
                       input bit abort, input bit track);
      exp_t e;
      if (track) begin
         e.data = b; e.eff = eff; e.gap = gap; e.abort = abort;
         sb.push_back(e);
      end
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_busy(input logic v, input string nm);
      int n = 0;
      while (busy !== v && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, busy, v);
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while (!(sb.size() == 0 && !mon_act && tc === 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, (sb.size() == 0 && tc === 1'b1), 1);
   endtask

   // Monitor: every falling txd outside a frame starts one expected frame.
   initial begin
      exp_t e;
      int   last_end = -100;
      int   start_cyc, bad, bitn;
      bit   ab;
      logic [7:0] rx;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && txd === 1'b0) begin
            mon_act = 1;
            start_cyc = cyc;
            chk("frame_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) e = sb.pop_front();
            else begin e.data = 8'h00; e.eff = 2; e.gap = 0; e.abort = 0; end
            if (e.gap) chk("frame_gap", start_cyc - last_end, 2);
            bad = 0; ab = 0; rx = '0;
            for (int c = 0; c < 10 * e.eff; c++) begin
               if (c > 0) @(negedge clk);
               if (resetn !== 1'b1) begin ab = 1; break; end
               bitn = c / e.eff;
               if (busy !== 1'b1) bad++;
               if (bitn == 0) begin
                  if (txd !== 1'b0) bad++;
               end else if (bitn == 9) begin
                  if (txd !== 1'b1) bad++;
               end else begin
                  if (c % e.eff == 0) rx[bitn-1] = txd;
                  else if (txd !== rx[bitn-1]) bad++;
               end
            end
            last_end = cyc;
            chk("frame_abort", ab, e.abort);
            if (!ab) begin
               chk("frame_byte", rx, e.data);
               chk("frame_timing_errs", bad, 0);
            end
            mon_act = 0;
         end
      end
   end

   initial begin
      int n, bad;
      resetn = 1'b0; tx_en = 1'b0; wr_en = 1'b0; wr_data = '0; cycles_per_bit = 32'd4;
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_txd", txd, 1); chk("rst_busy", busy, 0); chk("rst_tc", tc, 1);
      chk("rst_full", full, 0); chk("rst_empty", empty, 1); chk("rst_level", level, 0);
      chk("rst_drop", drop_count, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Single 0x55 frame at 4 clk/bit
      tx_en = 1'b1;
      push(8'h55, 4, 0, 0, 1);
      chk("t1_idle_txd", txd, 1);
      chk("t1_level", level, 1);
      chk("t1_tc_low", tc, 0);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy === 1'b1) n++;
         if (tc === 1'b1 && n > 0) break;
      end
      chk("t1_busy_len", n, 40);
      chk("t1_tc_back", tc, 1);
      drain("t1_drain", 200);

      // Three queued bytes at 3 clk/bit, back-to-back
      tx_en = 1'b0; cycles_per_bit = 32'd3;
      push(8'hA5, 3, 0, 0, 1);
      push(8'h0F, 3, 1, 0, 1);
      push(8'hFF, 3, 1, 0, 1);
      chk("t2_level3", level, 3);
      tx_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_busy(1, "t2_busy_rise");
         chk("t2_level_pop", level, 2 - i);
         wait_busy(0, "t2_busy_fall");
      end
      drain("t2_drain", 400);

      // Overflow: 18 writes into a 16-deep FIFO, then push on the pop cycle
      tx_en = 1'b0; cycles_per_bit = 32'd2;
      for (int i = 0; i < 18; i++) push(8'h10 + 8'(i), 2, (i != 0), 0, (i < 16));
      chk("t3_full", full, 1); chk("t3_level", level, 16); chk("t3_drop", drop_count, 2);
      begin
         exp_t e;
         e.data = 8'hC3; e.eff = 2; e.gap = 1; e.abort = 0;
         sb.push_back(e);
      end
      tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'hC3;
      @(negedge clk);
      wr_en = 1'b0;
      chk("t4_level", level, 16); chk("t4_full", full, 1); chk("t4_drop", drop_count, 2);
      drain("t3_drain", 2000);

      // Clamped bit period for cpb 1 and 0
      cycles_per_bit = 32'd1;
      push(8'h96, 2, 0, 0, 1);
      drain("t5_cpb1", 200);
      cycles_per_bit = 32'd0;
      push(8'h69, 2, 0, 0, 1);
      drain("t5_cpb0", 200);

      // cpb change mid-frame applies to the next frame only
      cycles_per_bit = 32'd4;
      push(8'h3C, 4, 0, 0, 1);
      push(8'h81, 8, 1, 0, 1);
      wait_busy(1, "t6_busy_rise");
      repeat (10) @(negedge clk);
      cycles_per_bit = 32'd8;
      drain("t6_drain", 400);

      // Asynchronous reset during data bit 3
      cycles_per_bit = 32'd4;
      push(8'h5A, 4, 0, 1, 1);
      push(8'h77, 4, 0, 0, 0);
      wait_busy(1, "t7_busy_rise");
      repeat (17) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("t7_txd", txd, 1); chk("t7_busy", busy, 0); chk("t7_empty", empty, 1);
      chk("t7_level", level, 0);
      @(negedge clk);
      resetn = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0 || tc !== 1'b1) bad++;
      end
      chk("t7_no_residual", bad, 0);
      chk("t7_sb_empty", sb.size(), 0);

      // drop_count wraps 255 -> 0
      tx_en = 1'b0;
      for (int i = 0; i < 271; i++) push(8'(i), 2, 0, 0, 0);
      chk("t8_drop255", drop_count, 255);
      push(8'hEE, 2, 0, 0, 0);
      chk("t8_drop_wrap", drop_count, 0);
      chk("t8_level", level, 16);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("t8_rst_level", level, 0);
      tx_en = 1'b1;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1);
   end

endmodule
